// File: rtl/trap_ctrl_pkg.sv
// Shared types and mstatus field positions for the trap/xret update controller.
package trap_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_DRAIN    = 2'd1,
        ST_COMMIT   = 2'd2,
        ST_REDIRECT = 2'd3
    } trap_state_e;

    typedef enum logic {
        KIND_TRAP = 1'b0,
        KIND_XRET = 1'b1
    } trap_kind_e;

    localparam int MSTATUS_MIE    = 3;
    localparam int MSTATUS_MPIE   = 7;
    localparam int MSTATUS_MPP_LO = 11;
    localparam int MSTATUS_MPP_HI = 12;

endpackage

// File: rtl/trap_ctrl.sv
// Initiator of CSR trap/MRET updates: accepts a request, drains the LSU,
// pulses the CSR commit for one cycle, then offers the redirect PC to fetch.
module trap_ctrl
    import trap_ctrl_pkg::*;
#(
    parameter int XLEN      = 64,
    parameter int ALEN      = 64,
    parameter int DRAIN_MAX = 255
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            exc_valid,
    input  logic [3:0]      exc_cause,
    input  logic [ALEN-1:0] exc_pc,
    input  logic [XLEN-1:0] exc_tval,
    output logic            exc_ready,
    input  logic            mret_valid,
    output logic            mret_ready,
    input  logic            mem_busy,
    input  logic [XLEN-1:0] mstatus,
    input  logic [XLEN-1:0] mtvec,
    input  logic [XLEN-1:0] mepc,
    input  logic [1:0]      privilege_mode,
    output logic            trap_do_update,
    output logic [3:0]      trap_mcause,
    output logic [ALEN-1:0] trap_mepc,
    output logic [XLEN-1:0] trap_mtval,
    output logic            xret_do_update,
    output logic [XLEN-1:0] xret_new_mstatus,
    output logic [1:0]      xret_new_privilege_mode,
    output logic            flush,
    output logic            redirect_valid,
    output logic [ALEN-1:0] redirect_pc,
    input  logic            redirect_ready,
    output logic            busy,
    output logic            drain_timeout_err
);

    localparam int CW = $clog2(DRAIN_MAX + 1);

    trap_state_e     r_state;
    trap_kind_e      r_kind;
    logic [3:0]      r_cause;
    logic [ALEN-1:0] r_pc;
    logic [XLEN-1:0] r_tval;
    logic [ALEN-1:0] r_redirect_pc;
    logic [CW-1:0]   r_drain_cnt;
    logic            r_flush;
    logic            r_timeout_err;

    logic            w_idle;
    logic            w_commit_trap;
    logic            w_commit_xret;
    logic            w_drain_last;
    logic [ALEN-1:0] w_target;
    logic [XLEN-1:0] w_mret_mstatus;
    logic            w_unused;

    assign w_idle        = (r_state == ST_IDLE);
    assign w_commit_trap = (r_state == ST_COMMIT) && (r_kind == KIND_TRAP);
    assign w_commit_xret = (r_state == ST_COMMIT) && (r_kind == KIND_XRET);
    assign w_drain_last  = (r_drain_cnt == CW'(DRAIN_MAX - 1));

    // No interrupts exist, so the mtvec mode field is ignored and every trap vectors to base.
    assign w_target = (r_kind == KIND_TRAP) ? {mtvec[ALEN-1:2], 2'b00} : mepc[ALEN-1:0];

    always_comb begin
        w_mret_mstatus                                 = mstatus;
        w_mret_mstatus[MSTATUS_MIE]                    = mstatus[MSTATUS_MPIE];
        w_mret_mstatus[MSTATUS_MPIE]                   = 1'b1;
        w_mret_mstatus[MSTATUS_MPP_HI:MSTATUS_MPP_LO]  = 2'b11;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= ST_IDLE;
            r_kind        <= KIND_TRAP;
            r_cause       <= '0;
            r_pc          <= '0;
            r_tval        <= '0;
            r_redirect_pc <= '0;
            r_drain_cnt   <= '0;
            r_flush       <= 1'b0;
            r_timeout_err <= 1'b0;
        end else begin
            r_flush <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (exc_valid) begin
                        r_kind      <= KIND_TRAP;
                        r_cause     <= exc_cause;
                        r_pc        <= exc_pc;
                        r_tval      <= exc_tval;
                        r_drain_cnt <= '0;
                        r_flush     <= 1'b1;
                        r_state     <= ST_DRAIN;
                    end else if (mret_valid) begin
                        r_kind      <= KIND_XRET;
                        r_drain_cnt <= '0;
                        r_flush     <= 1'b1;
                        r_state     <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    r_drain_cnt <= r_drain_cnt + CW'(1);
                    if (!mem_busy) begin
                        r_state <= ST_COMMIT;
                    end else if (w_drain_last) begin
                        r_timeout_err <= 1'b1;
                        r_state       <= ST_COMMIT;
                    end
                end
                ST_COMMIT: begin
                    r_redirect_pc <= w_target;
                    r_state       <= ST_REDIRECT;
                end
                ST_REDIRECT: begin
                    if (redirect_ready) begin
                        r_state <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign exc_ready  = w_idle;
    assign mret_ready = w_idle && !exc_valid;
    assign busy       = !w_idle;
    assign flush      = r_flush;

    assign trap_do_update = w_commit_trap;
    assign trap_mcause    = w_commit_trap ? r_cause : 4'd0;
    assign trap_mepc      = w_commit_trap ? {r_pc[ALEN-1:1], 1'b0} : '0;
    assign trap_mtval     = w_commit_trap ? r_tval : '0;

    assign xret_do_update          = w_commit_xret;
    assign xret_new_mstatus        = w_commit_xret ? w_mret_mstatus : '0;
    assign xret_new_privilege_mode = w_commit_xret ? mstatus[MSTATUS_MPP_HI:MSTATUS_MPP_LO] : 2'b00;

    assign redirect_valid    = (r_state == ST_REDIRECT);
    assign redirect_pc       = redirect_valid ? r_redirect_pc : '0;
    assign drain_timeout_err = r_timeout_err;

    // Inputs carried for interface completeness on an M-only core.
    assign w_unused = ^{mtvec, mepc, privilege_mode, r_pc[0]};

endmodule

// File: tb/tb_trap_ctrl.sv
// Self-checking bench for trap_ctrl: vector table plus hand sequences, with a scoreboard on commits/redirects.
module tb_trap_ctrl;

    typedef struct {
        logic        isTrap;
        logic [3:0]  cause;
        logic [63:0] mepc;
        logic [63:0] tval;
        logic [63:0] mstatus;
        logic [1:0]  priv;
        logic [63:0] rpc;
    } exp_t;

    typedef struct {
        string       name;
        logic        isMret;
        logic [3:0]  cause;
        logic [63:0] pc;
        logic [63:0] tval;
        logic [63:0] mtvec;
        logic [63:0] mstatus;
        logic [63:0] mepc;
        int          busyCycles;
        int          readyDelay;
        logic [63:0] expMepc;
        logic [63:0] expMstatus;
        logic [1:0]  expPriv;
        logic [63:0] expPc;
    } vec_t;

    localparam logic [3:0] EXC_ILLEGAL_INSTR = 4'd2;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        exc_valid, mret_valid, mem_busy, redirect_ready;
    logic [3:0]  exc_cause;
    logic [63:0] exc_pc, exc_tval, mstatus, mtvec, mepc;
    logic [1:0]  privilege_mode;

    logic        exc_ready, mret_ready, trap_do_update, xret_do_update, flush;
    logic        redirect_valid, busy, drain_timeout_err;
    logic [3:0]  trap_mcause;
    logic [63:0] trap_mepc, trap_mtval, xret_new_mstatus, redirect_pc;
    logic [1:0]  xret_new_privilege_mode;

    logic        b_exc_ready, b_mret_ready, b_trap_do_update, b_xret_do_update, b_flush;
    logic        b_redirect_valid, b_busy, b_drain_timeout_err;
    logic [3:0]  b_trap_mcause;
    logic [63:0] b_trap_mepc, b_trap_mtval, b_xret_new_mstatus, b_redirect_pc;
    logic [1:0]  b_xret_new_privilege_mode;

    int   total = 0;
    int   bad = 0;
    exp_t expQ[$];
    exp_t monExp;
    vec_t vecs[6];

    always #5 clk = ~clk;

    trap_ctrl #(.XLEN(64), .ALEN(64), .DRAIN_MAX(255)) dutA (
        .clk(clk), .rst_n(rst_n),
        .exc_valid(exc_valid), .exc_cause(exc_cause), .exc_pc(exc_pc), .exc_tval(exc_tval),
        .exc_ready(exc_ready), .mret_valid(mret_valid), .mret_ready(mret_ready),
        .mem_busy(mem_busy), .mstatus(mstatus), .mtvec(mtvec), .mepc(mepc),
        .privilege_mode(privilege_mode),
        .trap_do_update(trap_do_update), .trap_mcause(trap_mcause), .trap_mepc(trap_mepc),
        .trap_mtval(trap_mtval), .xret_do_update(xret_do_update),
        .xret_new_mstatus(xret_new_mstatus), .xret_new_privilege_mode(xret_new_privilege_mode),
        .flush(flush), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .redirect_ready(redirect_ready), .busy(busy), .drain_timeout_err(drain_timeout_err)
    );

    // Short-timeout instance sharing the same stimulus; only checked in the timeout sequence.
    trap_ctrl #(.XLEN(64), .ALEN(64), .DRAIN_MAX(4)) dutB (
        .clk(clk), .rst_n(rst_n),
        .exc_valid(exc_valid), .exc_cause(exc_cause), .exc_pc(exc_pc), .exc_tval(exc_tval),
        .exc_ready(b_exc_ready), .mret_valid(mret_valid), .mret_ready(b_mret_ready),
        .mem_busy(mem_busy), .mstatus(mstatus), .mtvec(mtvec), .mepc(mepc),
        .privilege_mode(privilege_mode),
        .trap_do_update(b_trap_do_update), .trap_mcause(b_trap_mcause), .trap_mepc(b_trap_mepc),
        .trap_mtval(b_trap_mtval), .xret_do_update(b_xret_do_update),
        .xret_new_mstatus(b_xret_new_mstatus), .xret_new_privilege_mode(b_xret_new_privilege_mode),
        .flush(b_flush), .redirect_valid(b_redirect_valid), .redirect_pc(b_redirect_pc),
        .redirect_ready(redirect_ready), .busy(b_busy), .drain_timeout_err(b_drain_timeout_err)
    );

    task automatic checkOutput(input string name, input logic [63:0] got, input logic [63:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("[TB] FAIL %s: got 0x%0h, want 0x%0h", name, got, want);
        end
    endtask

    // Scoreboard: commit pulses and redirect offers are compared against the oldest outstanding request.
    always @(negedge clk) begin
        if (rst_n) begin
            if (trap_do_update || xret_do_update) begin
                if (expQ.size() == 0) begin
                    total++;
                    bad++;
                    $display("[TB] FAIL unexpected_update: trap=%0b xret=%0b with nothing outstanding",
                             trap_do_update, xret_do_update);
                end else begin
                    monExp = expQ[0];
                    if (monExp.isTrap) begin
                        checkOutput("sb_trap_pulse", {63'd0, trap_do_update}, 64'd1);
                        checkOutput("sb_xret_quiet", {63'd0, xret_do_update}, 64'd0);
                        checkOutput("sb_mcause", {60'd0, trap_mcause}, {60'd0, monExp.cause});
                        checkOutput("sb_mepc", trap_mepc, monExp.mepc);
                        checkOutput("sb_mtval", trap_mtval, monExp.tval);
                    end else begin
                        checkOutput("sb_xret_pulse", {63'd0, xret_do_update}, 64'd1);
                        checkOutput("sb_trap_quiet", {63'd0, trap_do_update}, 64'd0);
                        checkOutput("sb_new_mstatus", xret_new_mstatus, monExp.mstatus);
                        checkOutput("sb_new_priv", {62'd0, xret_new_privilege_mode}, {62'd0, monExp.priv});
                    end
                end
            end
            if (redirect_valid) begin
                if (expQ.size() == 0) begin
                    total++;
                    bad++;
                    $display("[TB] FAIL unexpected_redirect: pc=0x%0h with nothing outstanding", redirect_pc);
                end else begin
                    checkOutput("sb_redirect_pc", redirect_pc, expQ[0].rpc);
                    if (redirect_ready) void'(expQ.pop_front());
                end
            end
        end
    end

    task automatic doReset();
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        exc_valid = 1'b0;
        mret_valid = 1'b0;
        mem_busy = 1'b0;
        redirect_ready = 1'b0;
        expQ.delete();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // One full request: accept, drain for busyCycles, commit, redirect after readyDelay stalls.
    task automatic applyStimulus(input vec_t v);
        exp_t e;
        @(posedge clk);
        #1;
        exc_valid = !v.isMret;
        mret_valid = v.isMret;
        exc_cause = v.cause;
        exc_pc = v.pc;
        exc_tval = v.tval;
        mtvec = ~v.mtvec;
        mstatus = ~v.mstatus;
        mepc = ~v.mepc;
        mem_busy = (v.busyCycles > 0);
        redirect_ready = (v.readyDelay == 0);
        @(negedge clk);
        checkOutput({v.name, "_accept_ready"}, {63'd0, v.isMret ? mret_ready : exc_ready}, 64'd1);
        e = '{isTrap: !v.isMret, cause: v.cause, mepc: v.expMepc, tval: v.tval,
              mstatus: v.expMstatus, priv: v.expPriv, rpc: v.expPc};
        expQ.push_back(e);
        @(posedge clk);
        #1;
        exc_valid = 1'b0;
        mret_valid = 1'b0;
        exc_cause = ~v.cause;
        exc_pc = ~v.pc;
        exc_tval = ~v.tval;
        mtvec = v.mtvec;
        mstatus = v.mstatus;
        mepc = v.mepc;
        @(negedge clk);
        checkOutput({v.name, "_flush"}, {63'd0, flush}, 64'd1);
        checkOutput({v.name, "_busy"}, {63'd0, busy}, 64'd1);
        checkOutput({v.name, "_drain_exc_ready"}, {63'd0, exc_ready}, 64'd0);
        for (int k = 2; k <= v.busyCycles + 1; k++) begin
            @(posedge clk);
            #1;
            if (k == v.busyCycles + 1) mem_busy = 1'b0;
            @(negedge clk);
            checkOutput({v.name, "_no_early_commit"}, {63'd0, trap_do_update | xret_do_update}, 64'd0);
            checkOutput({v.name, "_flush_once"}, {63'd0, flush}, 64'd0);
        end
        @(posedge clk);
        #1;
        @(negedge clk);
        checkOutput({v.name, "_commit_pulse"},
                    {63'd0, v.isMret ? xret_do_update : trap_do_update}, 64'd1);
        checkOutput({v.name, "_commit_no_redirect"}, {63'd0, redirect_valid}, 64'd0);
        for (int k = 0; k < v.readyDelay; k++) begin
            @(posedge clk);
            #1;
            @(negedge clk);
            checkOutput({v.name, "_stall_valid"}, {63'd0, redirect_valid}, 64'd1);
            checkOutput({v.name, "_stall_exc_ready"}, {63'd0, exc_ready}, 64'd0);
            checkOutput({v.name, "_single_pulse"}, {63'd0, trap_do_update | xret_do_update}, 64'd0);
        end
        @(posedge clk);
        #1;
        redirect_ready = 1'b1;
        @(negedge clk);
        checkOutput({v.name, "_redirect_valid"}, {63'd0, redirect_valid}, 64'd1);
        @(posedge clk);
        #1;
        @(negedge clk);
        checkOutput({v.name, "_back_idle"}, {63'd0, busy}, 64'd0);
        checkOutput({v.name, "_idle_exc_ready"}, {63'd0, exc_ready}, 64'd1);
        checkOutput({v.name, "_idle_no_redirect"}, {63'd0, redirect_valid}, 64'd0);
        checkOutput({v.name, "_no_timeout"}, {63'd0, drain_timeout_err}, 64'd0);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        exp_t e;
        rst_n = 1'b0;
        exc_valid = 1'b0;
        mret_valid = 1'b0;
        mem_busy = 1'b0;
        redirect_ready = 1'b0;
        exc_cause = '0;
        exc_pc = '0;
        exc_tval = '0;
        mstatus = '0;
        mtvec = '0;
        mepc = '0;
        privilege_mode = 2'b11;

        vecs[0] = '{name: "trap_basic", isMret: 1'b0, cause: EXC_ILLEGAL_INSTR,
                    pc: 64'h8000_0013, tval: 64'hDEAD, mtvec: 64'h8000_0101, mstatus: 64'h0,
                    mepc: 64'h0, busyCycles: 0, readyDelay: 0, expMepc: 64'h8000_0012,
                    expMstatus: 64'h0, expPriv: 2'b00, expPc: 64'h8000_0100};
        vecs[1] = '{name: "mret_basic", isMret: 1'b1, cause: 4'd0, pc: 64'h0, tval: 64'h0,
                    mtvec: 64'h0, mstatus: 64'h1880, mepc: 64'h8000_0040, busyCycles: 0,
                    readyDelay: 0, expMepc: 64'h0, expMstatus: 64'h1888, expPriv: 2'b11,
                    expPc: 64'h8000_0040};
        vecs[2] = '{name: "mret_mie_clear", isMret: 1'b1, cause: 4'd0, pc: 64'h0, tval: 64'h0,
                    mtvec: 64'h0, mstatus: 64'h0808, mepc: 64'h1234_5678_9ABC_DEF1, busyCycles: 1,
                    readyDelay: 0, expMepc: 64'h0, expMstatus: 64'h1880, expPriv: 2'b01,
                    expPc: 64'h1234_5678_9ABC_DEF1};
        vecs[3] = '{name: "mret_keep_bits", isMret: 1'b1, cause: 4'd0, pc: 64'h0, tval: 64'h0,
                    mtvec: 64'h0, mstatus: 64'hFFFF_FFFF_FFFF_E777, mepc: 64'h0, busyCycles: 0,
                    readyDelay: 1, expMepc: 64'h0, expMstatus: 64'hFFFF_FFFF_FFFF_FFF7,
                    expPriv: 2'b00, expPc: 64'h0};
        vecs[4] = '{name: "trap_drain5", isMret: 1'b0, cause: 4'd5, pc: 64'h1001, tval: 64'h0,
                    mtvec: 64'h2003, mstatus: 64'h0, mepc: 64'h0, busyCycles: 5, readyDelay: 0,
                    expMepc: 64'h1000, expMstatus: 64'h0, expPriv: 2'b00, expPc: 64'h2000};
        vecs[5] = '{name: "trap_backpressure", isMret: 1'b0, cause: 4'hF,
                    pc: 64'hFFFF_FFFF_FFFF_FFFF, tval: 64'h1234, mtvec: 64'hFFFF_FFFF_FFFF_FFFE,
                    mstatus: 64'h0, mepc: 64'h0, busyCycles: 0, readyDelay: 3,
                    expMepc: 64'hFFFF_FFFF_FFFF_FFFE, expMstatus: 64'h0, expPriv: 2'b00,
                    expPc: 64'hFFFF_FFFF_FFFF_FFFC};

        #2;
        checkOutput("reset_exc_ready", {63'd0, exc_ready}, 64'd1);
        checkOutput("reset_mret_ready", {63'd0, mret_ready}, 64'd1);
        checkOutput("reset_busy", {63'd0, busy}, 64'd0);
        checkOutput("reset_flush", {63'd0, flush}, 64'd0);
        checkOutput("reset_redirect_valid", {63'd0, redirect_valid}, 64'd0);
        checkOutput("reset_timeout_err", {63'd0, drain_timeout_err}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 6; i++) applyStimulus(vecs[i]);

        // Simultaneous exception and MRET: trap first, MRET on the next IDLE cycle.
        @(posedge clk);
        #1;
        exc_valid = 1'b1;
        mret_valid = 1'b1;
        exc_cause = 4'd3;
        exc_pc = 64'h400;
        exc_tval = 64'h55;
        mtvec = 64'h1000;
        mstatus = 64'h80;
        mepc = 64'h2000;
        mem_busy = 1'b0;
        redirect_ready = 1'b1;
        @(negedge clk);
        checkOutput("simul_exc_ready", {63'd0, exc_ready}, 64'd1);
        checkOutput("simul_mret_ready", {63'd0, mret_ready}, 64'd0);
        e = '{isTrap: 1'b1, cause: 4'd3, mepc: 64'h400, tval: 64'h55, mstatus: 64'h0,
              priv: 2'b00, rpc: 64'h1000};
        expQ.push_back(e);
        @(posedge clk);
        #1;
        exc_valid = 1'b0;
        for (int k = 1; k <= 3; k++) begin
            @(negedge clk);
            checkOutput("simul_mret_held_off", {63'd0, mret_ready}, 64'd0);
            @(posedge clk);
            #1;
        end
        @(negedge clk);
        checkOutput("simul_mret_accept", {63'd0, mret_ready}, 64'd1);
        e = '{isTrap: 1'b0, cause: 4'd0, mepc: 64'h0, tval: 64'h0, mstatus: 64'h1888,
              priv: 2'b00, rpc: 64'h2000};
        expQ.push_back(e);
        @(posedge clk);
        #1;
        mret_valid = 1'b0;
        @(negedge clk);
        @(posedge clk);
        #1;
        @(negedge clk);
        checkOutput("simul_xret_pulse", {63'd0, xret_do_update}, 64'd1);
        repeat (3) @(negedge clk);
        checkOutput("simul_queue_drained", 64'(expQ.size()), 64'd0);

        // Drain timeout on the DRAIN_MAX=4 instance with mem_busy stuck high.
        doReset();
        @(posedge clk);
        #1;
        exc_valid = 1'b1;
        exc_cause = 4'd7;
        exc_pc = 64'h3000;
        exc_tval = 64'h77;
        mtvec = 64'h4000;
        mem_busy = 1'b1;
        redirect_ready = 1'b1;
        @(negedge clk);
        checkOutput("to_accept", {63'd0, b_exc_ready}, 64'd1);
        @(posedge clk);
        #1;
        exc_valid = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            checkOutput("to_no_early_commit", {63'd0, b_trap_do_update}, 64'd0);
            checkOutput("to_err_not_yet", {63'd0, b_drain_timeout_err}, 64'd0);
            @(posedge clk);
            #1;
        end
        @(negedge clk);
        checkOutput("to_commit", {63'd0, b_trap_do_update}, 64'd1);
        checkOutput("to_err_set", {63'd0, b_drain_timeout_err}, 64'd1);
        checkOutput("to_mepc", b_trap_mepc, 64'h3000);
        checkOutput("to_long_still_draining", {63'd0, busy & ~trap_do_update}, 64'd1);
        @(negedge clk);
        checkOutput("to_redirect_pc", b_redirect_pc, 64'h4000);
        @(negedge clk);
        checkOutput("to_idle", {63'd0, b_busy}, 64'd0);
        checkOutput("to_err_sticky", {63'd0, b_drain_timeout_err}, 64'd1);
        doReset();
        checkOutput("to_err_cleared", {63'd0, b_drain_timeout_err}, 64'd0);

        // Reset while draining aborts the request with no commit afterwards.
        @(posedge clk);
        #1;
        exc_valid = 1'b1;
        exc_cause = 4'd1;
        exc_pc = 64'h500;
        mem_busy = 1'b1;
        redirect_ready = 1'b1;
        @(posedge clk);
        #1;
        exc_valid = 1'b0;
        @(negedge clk);
        checkOutput("rst_pre_busy", {63'd0, busy}, 64'd1);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("rst_busy", {63'd0, busy}, 64'd0);
        checkOutput("rst_flush", {63'd0, flush}, 64'd0);
        checkOutput("rst_trap_pulse", {63'd0, trap_do_update}, 64'd0);
        checkOutput("rst_redirect_valid", {63'd0, redirect_valid}, 64'd0);
        checkOutput("rst_exc_ready", {63'd0, exc_ready}, 64'd1);
        @(negedge clk);
        mem_busy = 1'b0;
        rst_n = 1'b1;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            checkOutput("rst_no_late_update", {63'd0, trap_do_update}, 64'd0);
        end
        checkOutput("rst_idle_after", {63'd0, busy}, 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
